vpu_src_stream_model: RTL

Parametrised, synthesizable SRAM read-port responder that feeds the VPU source ports during block-level and FPGA-prototype runs. It generalises the fixed three-port, fixed-latency read stimulus into N_PORT independent channels. Each channel has a preloadable replay FIFO, an alternative LFSR data mode, a configurable read latency, per-port transaction counters, underflow detection and a global done flag. It sits between the host/preload logic and the VPU_TOP source-port read interfaces.

---
 rtl/vpu_src_stream_model_if.sv | 28 ++
 rtl/vpu_src_stream_model.sv | 86 ++++++++
 2 files changed

// File: rtl/vpu_src_stream_model_if.sv
// vpu_src_stream_model_if: preload, read-port and status bundle between host/VPU side and the source responder
interface vpu_src_stream_model_if #(
  parameter int N_PORT = 3,
  parameter int DATA_W = 512,
  parameter int CNT_W = 16
);
  localparam int PW = N_PORT > 1 ? $clog2(N_PORT) : 1;
  logic cfg_mode;
  logic [CNT_W-1:0] cfg_iter;
  logic push_valid;
  logic [PW-1:0] push_port;
  logic [DATA_W-1:0] push_data;
  logic push_ready;
  logic [N_PORT-1:0] rd_en;
  logic [N_PORT*DATA_W-1:0] rd_data;
  logic [N_PORT-1:0] rd_valid;
  logic [N_PORT*CNT_W-1:0] rd_cnt;
  logic [N_PORT-1:0] underflow;
  logic done;
  modport master (
    output cfg_mode, cfg_iter, push_valid, push_port, push_data, rd_en,
    input push_ready, rd_data, rd_valid, rd_cnt, underflow, done
  );
  modport slave (
    input cfg_mode, cfg_iter, push_valid, push_port, push_data, rd_en,
    output push_ready, rd_data, rd_valid, rd_cnt, underflow, done
  );
endinterface

// File: rtl/vpu_src_stream_model.sv
// vpu_src_stream_model: per-port SRAM read responder with replay FIFO or LFSR data, fixed read latency and completion tracking
module vpu_src_stream_model #(
  parameter int N_PORT = 3,
  parameter int DATA_W = 512,
  parameter int DEPTH = 8,
  parameter int RD_LAT = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  vpu_src_stream_model_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = N_PORT > 1 ? $clog2(N_PORT) : 1;
  localparam logic [31:0] POLY = 32'h8020_0003;
  logic [N_PORT-1:0] full;
  logic [N_PORT-1:0] busy_n;
  logic [N_PORT-1:0] reach_n;
  logic pr;
  logic done;
  // push_ready looks only at the registered fill level of the addressed port; unknown ports always accept
  always_comb begin
    pr = 1'b1;
    for (int i = 0; i < N_PORT; i++) pr = bus.push_port == PW'(i) ? !full[i] : pr;
  end
  assign bus.push_ready = pr;
  for (genvar p = 0; p < N_PORT; p++) begin : g_port
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic [AW:0] cnt;
    logic [31:0] lfsr;
    logic [RD_LAT-1:0] pv, pv_n;
    logic [DATA_W-1:0] pd [RD_LAT];
    logic [CNT_W-1:0] rc, rc_n;
    logic uf, ld, push, pop, empty;
    logic [DATA_W-1:0] word;
    // pop/push decisions use pre-edge state, so a push into an empty FIFO never bypasses a same-cycle pop
    always_comb begin
      ld = bus.rd_en[p];
      empty = cnt == '0;
      push = bus.push_valid && bus.push_port == PW'(p) && !full[p];
      pop = ld && !bus.cfg_mode && !empty;
      word = bus.cfg_mode ? {(DATA_W/32){lfsr}} : (empty ? '0 : mem[rp]);
      pv_n = RD_LAT'({pv, ld});
      rc_n = pv[RD_LAT-1] && rc != '1 ? rc + 1'b1 : rc;
    end
    // storage array carries no reset; emptiness is tracked by the pointers and count
    always_ff @(posedge clk) if (push) mem[wp] <= bus.push_data;
    // FIFO pointers, LFSR, latency pipe, counters and sticky underflow
    always_ff @(posedge clk) begin
      if (rst) begin
        rp <= '0;
        wp <= '0;
        cnt <= '0;
        lfsr <= 32'hACE1_0000 + 32'(p);
        pv <= '0;
        rc <= '0;
        uf <= 1'b0;
        for (int k = 0; k < RD_LAT; k++) pd[k] <= '0;
      end else begin
        wp <= push ? wp + 1'b1 : wp;
        rp <= pop ? rp + 1'b1 : rp;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        lfsr <= ld && bus.cfg_mode ? {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0) : lfsr;
        pv <= pv_n;
        rc <= rc_n;
        uf <= uf | (ld && !bus.cfg_mode && empty);
        pd[0] <= ld ? word : pd[0];
        for (int k = 1; k < RD_LAT; k++) pd[k] <= pv[k-1] ? pd[k-1] : pd[k];
      end
    end
    assign full[p] = cnt == (AW+1)'(DEPTH);
    assign busy_n[p] = |pv_n;
    assign reach_n[p] = rc_n >= bus.cfg_iter;
    assign bus.rd_valid[p] = pv[RD_LAT-1];
    assign bus.rd_data[p*DATA_W +: DATA_W] = pd[RD_LAT-1];
    assign bus.rd_cnt[p*CNT_W +: CNT_W] = rc;
    assign bus.underflow[p] = uf;
  end
  // done is registered from next-state counts and pipe valids so it rises one cycle after the final rd_valid
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else done <= bus.cfg_iter != '0 && &reach_n && !(|busy_n);
  end
  assign bus.done = done;
endmodule
